// File: rtl/fir_sequencer.sv
// Micro-op sequencer for the 4-tap FIR datapath: arbitrates coefficient writes
// against new samples and walks the fixed store/multiply/accumulate/shift schedule.
module fir_sequencer (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       data_ready,
  input  logic       load_coeff,
  input  logic [1:0] coefficient_num,
  input  logic       overflow,
  output logic [2:0] op,
  output logic [3:0] src1,
  output logic [3:0] src2,
  output logic [3:0] dest,
  output logic       cnt_up,
  output logic       modwait,
  output logic       err
);

  typedef enum logic [3:0] {
    IDLE, EIDLE, COEFF, STORE,
    MUL0, MUL1, ACC1, MUL2, ACC2, MUL3, ACC3,
    SH3, SH2, SH1
  } state_t;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_COPY  = 3'b001;
  localparam logic [2:0] OP_LDS   = 3'b010;
  localparam logic [2:0] OP_LDC   = 3'b011;
  localparam logic [2:0] OP_ADD   = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b110;

  state_t     state, next_state;
  logic [1:0] coeff_idx;
  logic       accept;

  // Requests are only honoured while parked; the schedule itself never queues them.
  assign accept = (state == IDLE) || (state == EIDLE);

  always_ff @(posedge clk or posedge n_reset) begin
    if (n_reset) begin
      state     <= IDLE;
      coeff_idx <= 2'd0;
      modwait   <= 1'b0;
    end else begin
      state   <= next_state;
      modwait <= (next_state != IDLE) && (next_state != EIDLE);
      if (accept && load_coeff)
        coeff_idx <= coefficient_num;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, EIDLE: begin
        if (load_coeff)      next_state = COEFF;
        else if (data_ready) next_state = STORE;
      end
      COEFF: next_state = IDLE;
      STORE: next_state = MUL0;
      MUL0:  next_state = overflow ? EIDLE : MUL1;
      MUL1:  next_state = overflow ? EIDLE : ACC1;
      ACC1:  next_state = overflow ? EIDLE : MUL2;
      MUL2:  next_state = overflow ? EIDLE : ACC2;
      ACC2:  next_state = overflow ? EIDLE : MUL3;
      MUL3:  next_state = overflow ? EIDLE : ACC3;
      ACC3:  next_state = overflow ? EIDLE : SH3;
      SH3:   next_state = SH2;
      SH2:   next_state = SH1;
      SH1:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // R0 acc, R1..R4 history (R1 newest), R5 product temp, R6..R9 coefficients.
  always_comb begin
    op     = OP_NOP;
    src1   = 4'd0;
    src2   = 4'd0;
    dest   = 4'd0;
    cnt_up = 1'b0;
    err    = 1'b0;
    case (state)
      EIDLE: err = 1'b1;
      COEFF: begin op = OP_LDC; dest = 4'd6 + {2'b00, coeff_idx}; end
      STORE: begin op = OP_LDS; dest = 4'd1; cnt_up = 1'b1; end
      MUL0:  begin op = OP_MUL; src1 = 4'd1; src2 = 4'd6; dest = 4'd0; end
      MUL1:  begin op = OP_MUL; src1 = 4'd2; src2 = 4'd7; dest = 4'd5; end
      MUL2:  begin op = OP_MUL; src1 = 4'd3; src2 = 4'd8; dest = 4'd5; end
      MUL3:  begin op = OP_MUL; src1 = 4'd4; src2 = 4'd9; dest = 4'd5; end
      ACC1, ACC2, ACC3: begin op = OP_ADD; src1 = 4'd0; src2 = 4'd5; dest = 4'd0; end
      SH3:   begin op = OP_COPY; src1 = 4'd3; dest = 4'd4; end
      SH2:   begin op = OP_COPY; src1 = 4'd2; dest = 4'd3; end
      SH1:   begin op = OP_COPY; src1 = 4'd1; dest = 4'd2; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer: every output vector is compared against
// hand-written constants packed as {op, src1, src2, dest, cnt_up, modwait, err}.
module tb_fir_sequencer;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       data_ready, load_coeff, overflow;
  logic [1:0] coefficient_num;
  logic [2:0] op;
  logic [3:0] src1, src2, dest;
  logic       cnt_up, modwait, err;

  int nvec = 0;
  int nerr = 0;

  fir_sequencer dut (
    .clk(clk), .n_reset(n_reset), .data_ready(data_ready), .load_coeff(load_coeff),
    .coefficient_num(coefficient_num), .overflow(overflow), .op(op), .src1(src1),
    .src2(src2), .dest(dest), .cnt_up(cnt_up), .modwait(modwait), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] mk(input int o, s1, s2, d, cu, mw, er);
    return {o[2:0], s1[3:0], s2[3:0], d[3:0], cu[0], mw[0], er[0]};
  endfunction

  logic [17:0] sched [11];
  logic [17:0] idle_v, eidle_v;

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] obs();
    return {op, src1, src2, dest, cnt_up, modwait, err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    sched[0]  = mk(2, 0, 0, 1, 1, 1, 0);  // STORE
    sched[1]  = mk(6, 1, 6, 0, 0, 1, 0);  // MUL0
    sched[2]  = mk(6, 2, 7, 5, 0, 1, 0);  // MUL1
    sched[3]  = mk(4, 0, 5, 0, 0, 1, 0);  // ACC1
    sched[4]  = mk(6, 3, 8, 5, 0, 1, 0);  // MUL2
    sched[5]  = mk(4, 0, 5, 0, 0, 1, 0);  // ACC2
    sched[6]  = mk(6, 4, 9, 5, 0, 1, 0);  // MUL3
    sched[7]  = mk(4, 0, 5, 0, 0, 1, 0);  // ACC3
    sched[8]  = mk(1, 3, 0, 4, 0, 1, 0);  // SH3
    sched[9]  = mk(1, 2, 0, 3, 0, 1, 0);  // SH2
    sched[10] = mk(1, 1, 0, 2, 0, 1, 0);  // SH1
    idle_v  = mk(0, 0, 0, 0, 0, 0, 0);
    eidle_v = mk(0, 0, 0, 0, 0, 0, 1);

    n_reset = 1'b1; data_ready = 1'b0; load_coeff = 1'b0; overflow = 1'b0;
    coefficient_num = 2'd0;
    tick(); tick();
    chk("reset", obs(), idle_v);
    n_reset = 1'b0;
    tick();
    chk("idle_after_reset", obs(), idle_v);

    // Coefficient loads; index is scrambled after capture to prove it was latched.
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = (i == 0) ? 2 : (i == 1) ? 0 : (i == 2) ? 1 : 3;
      load_coeff = 1'b1; coefficient_num = idx[1:0];
      tick();
      load_coeff = 1'b0; coefficient_num = ~idx[1:0];
      chk($sformatf("coeff%0d", idx), obs(), mk(3, 0, 0, 6 + idx, 0, 1, 0));
      tick();
      chk($sformatf("coeff%0d_idle", idx), obs(), idle_v);
    end

    // Clean sample schedule.
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("sched%0d", k), obs(), sched[k]);
      tick();
    end
    chk("sched_end_idle", obs(), idle_v);

    // Priority: both requests together -> COEFF first.
    load_coeff = 1'b1; data_ready = 1'b1; coefficient_num = 2'd1;
    tick();
    load_coeff = 1'b0; data_ready = 1'b0;
    chk("prio_coeff", obs(), mk(3, 0, 0, 7, 0, 1, 0));
    tick();
    chk("prio_idle", obs(), idle_v);

    // data_ready pulsed during MUL1 is ignored.
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("busy%0d", k), obs(), sched[k]);
      data_ready = (k == 2);
      tick();
    end
    data_ready = 1'b0;
    chk("busy_end_idle", obs(), idle_v);
    tick();
    chk("busy_no_restart", obs(), idle_v);

    // Overflow during ACC2: ADD still issued, then EIDLE, no shifts.
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("ovf%0d", k), obs(), sched[k]);
      overflow = (k == 5);
      tick();
    end
    overflow = 1'b0;
    chk("eidle", obs(), eidle_v);
    tick();
    chk("eidle_hold", obs(), eidle_v);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    chk("eidle_exit_store", obs(), sched[0]);
    for (int k = 1; k < 11; k++) tick();
    tick();
    chk("post_ovf_idle", obs(), idle_v);

    // Overflow outside MUL0..ACC3 (STORE, SH3) must be ignored.
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("ovf_ign%0d", k), obs(), sched[k]);
      overflow = (k == 0) || (k == 8);
      tick();
    end
    overflow = 1'b0;
    chk("ovf_ign_idle", obs(), idle_v);

    // Reset asserted mid-ACC2 aborts at once.
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("rst_pre_acc2", obs(), sched[5]);
    n_reset = 1'b1;
    #1;
    chk("rst_async", obs(), idle_v);
    tick();
    chk("rst_next", obs(), idle_v);
    n_reset = 1'b0;
    tick();
    chk("rst_release", obs(), idle_v);

    // Held data_ready: cnt_up every 12 cycles, one IDLE between schedules.
    data_ready = 1'b1;
    tick();
    for (int c = 0; c < 25; c++) begin
      chk($sformatf("held%0d", c), obs(),
          ((c % 12) == 11) ? idle_v : sched[c % 12]);
      tick();
    end
    data_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
